// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, GRS bit positions, exponent helpers.
package fpu_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RUP = 2'd2,
    RM_RDN = 2'd3
  } round_mode_e;

  localparam int GRS_G = 2;
  localparam int GRS_R = 1;
  localparam int GRS_S = 0;

  function automatic int exp_all_ones(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/fpu_norm_round_pipe_if.sv
// Valid/ready bus for the normalise-and-round stage: raw result in, IEEE result out.
interface fpu_norm_round_pipe_if #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_sign;
  logic [Exponent_Size-1:0]   in_exponent;
  logic [Mantissa_Size+4:0]   in_mantissa;
  logic [1:0]                 in_round_mode;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_sign;
  logic [Exponent_Size-1:0]   out_exponent;
  logic [Mantissa_Size-1:0]   out_fraction;
  logic                       out_overflow;
  logic                       out_underflow;
  logic                       out_inexact;

  modport master (
    output in_valid, in_sign, in_exponent, in_mantissa, in_round_mode, out_ready,
    input  in_ready, out_valid, out_sign, out_exponent, out_fraction,
           out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exponent, in_mantissa, in_round_mode, out_ready,
    output in_ready, out_valid, out_sign, out_exponent, out_fraction,
           out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_norm_round_pipe.sv
// Three-stage normalise / round / exception pipeline with a single global advance.
module fpu_norm_round_pipe
  import fpu_pkg::*;
#(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8
) (
  input logic                clk,
  input logic                rst_n,
  fpu_norm_round_pipe_if.slave bus
);

  localparam int M      = Mantissa_Size;
  localparam int E      = Exponent_Size;
  localparam int XW     = E + 2;
  localparam int LZW    = $clog2(M + 5);
  localparam int STAGES = 3;
  localparam logic [E-1:0]         EXP_ONES   = E'(exp_all_ones(E));
  localparam logic signed [XW-1:0] EXP_ONES_X = XW'(exp_all_ones(E));

  logic              adv;
  logic [STAGES:1]   vld_pipe;

  assign adv           = ~vld_pipe[STAGES] | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
  end

  // ---------------- stage 1: normalise ----------------
  logic [LZW-1:0]          lz;
  logic signed [XW-1:0]    exp_in, lz_x, lim, shamt, n_exp;
  logic [M+3:0]            n_mant;
  logic                    n_special;

  fpu_lzc #(.WIDTH(M + 4)) u_lzc (
    .din (bus.in_mantissa[M+3:0]),
    .cnt (lz)
  );

  always_comb begin
    exp_in    = XW'(bus.in_exponent);
    lz_x      = XW'(lz);
    lim       = exp_in - 1;
    shamt     = '0;
    n_exp     = exp_in;
    n_mant    = bus.in_mantissa[M+3:0];
    n_special = (bus.in_exponent == EXP_ONES);
    if (!n_special) begin
      if (bus.in_mantissa[M+4]) begin
        n_mant    = bus.in_mantissa[M+4:1];
        n_mant[0] = |bus.in_mantissa[1:0];
        n_exp     = exp_in + 1;
      end else begin
        // Never shift below biased exponent 1: the rest stays subnormal.
        if (exp_in != '0) shamt = (lz_x < lim) ? lz_x : lim;
        n_mant = bus.in_mantissa[M+3:0] << shamt;
        n_exp  = exp_in - shamt;
      end
      if (!n_mant[M+3]) n_exp = '0;
    end
  end

  logic                 s1_sign, s1_special;
  logic signed [XW-1:0] s1_exp;
  logic [M+3:0]         s1_mant;
  round_mode_e          s1_rm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sign    <= 1'b0;
      s1_special <= 1'b0;
      s1_exp     <= '0;
      s1_mant    <= '0;
      s1_rm      <= RM_RNE;
    end else if (adv) begin
      s1_sign    <= bus.in_sign;
      s1_special <= n_special;
      s1_exp     <= n_exp;
      s1_mant    <= n_mant;
      s1_rm      <= round_mode_e'(bus.in_round_mode);
    end
  end

  // ---------------- stage 2: round ----------------
  logic [M:0]           sig;
  logic [M+1:0]         sum;
  logic                 g, r, st, inx, inc;
  logic signed [XW-1:0] r_exp;
  logic [M-1:0]         r_frac;

  always_comb begin
    sig = s1_mant[M+3:3];
    g   = s1_mant[GRS_G];
    r   = s1_mant[GRS_R];
    st  = s1_mant[GRS_S];
    inx = g | r | st;
    inc = 1'b0;
    case (s1_rm)
      RM_RNE: inc = g & (r | st | sig[0]);
      RM_RTZ: inc = 1'b0;
      RM_RUP: inc = inx & ~s1_sign;
      RM_RDN: inc = inx & s1_sign;
    endcase
    sum    = {1'b0, sig} + {{(M+1){1'b0}}, inc};
    r_exp  = s1_exp;
    r_frac = sum[M-1:0];
    if (sum[M+1]) begin
      r_frac = sum[M:1];
      r_exp  = s1_exp + 1;
    end else if (sum[M] && s1_exp == '0) begin
      r_exp = XW'(1);
    end
    if (s1_special) begin
      r_frac = sig[M-1:0];
      r_exp  = EXP_ONES_X;
      inx    = 1'b0;
    end
  end

  logic                 s2_sign, s2_special, s2_inexact;
  logic signed [XW-1:0] s2_exp;
  logic [M-1:0]         s2_frac;
  round_mode_e          s2_rm;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_sign    <= 1'b0;
      s2_special <= 1'b0;
      s2_inexact <= 1'b0;
      s2_exp     <= '0;
      s2_frac    <= '0;
      s2_rm      <= RM_RNE;
    end else if (adv) begin
      s2_sign    <= s1_sign;
      s2_special <= s1_special;
      s2_inexact <= inx;
      s2_exp     <= r_exp;
      s2_frac    <= r_frac;
      s2_rm      <= s1_rm;
    end
  end

  // ---------------- stage 3: exceptions ----------------
  logic [E-1:0] o_exp;
  logic [M-1:0] o_frac;
  logic         o_ovf, o_udf, o_inx, to_inf;

  always_comb begin
    to_inf = (s2_rm == RM_RNE) | ((s2_rm == RM_RUP) & ~s2_sign) |
             ((s2_rm == RM_RDN) & s2_sign);
    o_exp  = s2_exp[E-1:0];
    o_frac = s2_frac;
    o_ovf  = 1'b0;
    o_udf  = 1'b0;
    o_inx  = s2_inexact;
    if (s2_special) begin
      o_inx = 1'b0;
    end else if (s2_exp >= EXP_ONES_X) begin
      o_ovf  = 1'b1;
      o_inx  = 1'b1;
      o_exp  = to_inf ? EXP_ONES : EXP_ONES - 1'b1;
      o_frac = to_inf ? '0 : '1;
    end else begin
      o_udf = (s2_exp == '0) & s2_inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_sign      <= 1'b0;
      bus.out_exponent  <= '0;
      bus.out_fraction  <= '0;
      bus.out_overflow  <= 1'b0;
      bus.out_underflow <= 1'b0;
      bus.out_inexact   <= 1'b0;
    end else if (adv) begin
      bus.out_sign      <= s2_sign;
      bus.out_exponent  <= o_exp;
      bus.out_fraction  <= o_frac;
      bus.out_overflow  <= o_ovf;
      bus.out_underflow <= o_udf;
      bus.out_inexact   <= o_inx;
    end
  end

endmodule

// File: tb/tb_fpu_norm_round_pipe.sv
// Directed-vector bench for fpu_norm_round_pipe: rounding, limits, backpressure, reset.
module tb_fpu_norm_round_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_norm_round_pipe_if #(.Mantissa_Size(23), .Exponent_Size(8)) bus ();

  fpu_norm_round_pipe #(.Mantissa_Size(23), .Exponent_Size(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [34:0] pk(input logic s, input logic [7:0] e, input logic [22:0] f,
                                     input logic o, input logic u, input logic x);
    return {s, e, f, o, u, x};
  endfunction

  function automatic logic [34:0] obs();
    return {bus.out_sign, bus.out_exponent, bus.out_fraction,
            bus.out_overflow, bus.out_underflow, bus.out_inexact};
  endfunction

  task automatic drive(input logic s, input logic [7:0] e, input logic [27:0] m,
                       input logic [1:0] rm);
    bus.in_sign       = s;
    bus.in_exponent   = e;
    bus.in_mantissa   = m;
    bus.in_round_mode = rm;
  endtask

  // One beat through an idle pipe; checks result and edges-to-valid (accept edge counts as 1).
  task automatic single(input string tag, input logic s, input logic [7:0] e,
                        input logic [27:0] m, input logic [1:0] rm, input logic [34:0] want);
    int edges;
    @(negedge clk);
    drive(s, e, m, rm);
    bus.in_valid = 1'b1;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, "_valid"}, bus.out_valid, 1);
    if (bus.out_valid) begin
      chk(tag, obs(), want);
      chk({tag, "_lat"}, edges, 3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [34:0] exp_q[$];
    int   sent, rcv, stalls, stale;
    logic acc;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 8'd0, 28'd0, RM_RNE);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_data", obs(), 0);
    rst_n = 1'b1;

    single("carry",       0, 8'd127, 28'hC000000, RM_RNE, pk(0, 8'd128, 23'h400000, 0, 0, 0));
    single("left",        0, 8'd100, 28'h0000008, RM_RNE, pk(0, 8'd77,  23'h0,      0, 0, 0));
    single("tie_rne",     0, 8'd127, 28'h400000C, RM_RNE, pk(0, 8'd127, 23'h2,      0, 0, 1));
    single("tie_rtz",     0, 8'd127, 28'h400000C, RM_RTZ, pk(0, 8'd127, 23'h1,      0, 0, 1));
    single("tie_rup_pos", 0, 8'd127, 28'h400000C, RM_RUP, pk(0, 8'd127, 23'h2,      0, 0, 1));
    single("tie_rup_neg", 1, 8'd127, 28'h400000C, RM_RUP, pk(1, 8'd127, 23'h1,      0, 0, 1));
    single("even_rne",    0, 8'd127, 28'h4000004, RM_RNE, pk(0, 8'd127, 23'h0,      0, 0, 1));
    single("ovf_rne",     0, 8'd254, 28'hFFFFFFF, RM_RNE, pk(0, 8'd255, 23'h0,      1, 0, 1));
    single("ovf_rtz",     0, 8'd254, 28'hFFFFFFF, RM_RTZ, pk(0, 8'd254, 23'h7FFFFF, 1, 0, 1));
    single("ovf_rdn_pos", 0, 8'd254, 28'hFFFFFFF, RM_RDN, pk(0, 8'd254, 23'h7FFFFF, 1, 0, 1));
    single("ovf_rdn_neg", 1, 8'd254, 28'hFFFFFFF, RM_RDN, pk(1, 8'd255, 23'h0,      1, 0, 1));
    single("ovf_rup_neg", 1, 8'd254, 28'hFFFFFFF, RM_RUP, pk(1, 8'd254, 23'h7FFFFF, 1, 0, 1));
    single("subn",        0, 8'd3,   28'h0000008, RM_RNE, pk(0, 8'd0,   23'h4,      0, 0, 0));
    single("subn_inx",    0, 8'd3,   28'h0000009, RM_RNE, pk(0, 8'd0,   23'h4,      0, 1, 1));
    single("subn_to_norm",0, 8'd1,   28'h3FFFFFC, RM_RNE, pk(0, 8'd1,   23'h0,      0, 0, 1));
    single("tiny_rtz",    0, 8'd1,   28'h0000001, RM_RTZ, pk(0, 8'd0,   23'h0,      0, 1, 1));
    single("zero",        1, 8'd50,  28'h0000000, RM_RNE, pk(1, 8'd0,   23'h0,      0, 0, 0));
    single("nan",         0, 8'd255, 28'h0000018, RM_RNE, pk(0, 8'd255, 23'h3,      0, 0, 0));
    single("special_raw", 0, 8'd255, 28'hFFFFFFF, RM_RUP, pk(0, 8'd255, 23'h7FFFFF, 0, 0, 0));

    // Five carry-normalise beats, exponents 10..14, with the consumer stalled on cycles 3..6.
    for (int i = 0; i < 5; i++) exp_q.push_back(pk(0, 8'(11 + i), 23'h400000, 0, 0, 0));
    sent = 0; rcv = 0; stalls = 0;
    for (int c = 0; c < 40 && rcv < 5; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 3 && c <= 6);
      bus.in_valid  = (sent < 5);
      drive(1'b0, 8'(10 + sent), 28'hC000000, RM_RNE);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_hold", obs(), exp_q[rcv]);
      end
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("bp_beat%0d", rcv), obs(), exp_q[rcv]);
        rcv++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    chk("bp_count", rcv, 5);
    chk("bp_stalls", stalls, 4);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset with three beats in flight.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 8'(40 + c), 28'h4000000, RM_RNE);
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_data", obs(), 0);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("rst_stale", stale, 0);

    single("post_rst", 0, 8'd127, 28'hC000000, RM_RNE, pk(0, 8'd128, 23'h400000, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
